rect_draw_engine: RTL and testbench

Parametrised rectangle rasteriser that converts one draw command (position, size, colour, mode) into a sequence of row-aligned write bursts for the framebuffer memory controller. Supports solid fill and 1-pixel outline, clips to the screen, and splits long rows into bursts of at most MAX_BURST_LEN. Sits between the graphics command decoder and the SDRAM write-burst port.

---
 rtl/rect_draw_engine.sv | 206 ++++++++++++++++++++
 tb/tb_rect_draw_engine.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: turns one fill/outline command into clipped,
// row-aligned framebuffer write bursts.
module rect_draw_engine #(
    parameter int PIXEL_BITS    = 16,
    parameter int COORD_BITS    = 10,
    parameter int ADDR_BITS     = 22,
    parameter int BURST_BITS    = 10,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int MAX_BURST_LEN = 128,
    parameter int FB_BASE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [COORD_BITS-1:0] x_pixel,
    input  logic [COORD_BITS-1:0] y_pixel,
    input  logic [COORD_BITS-1:0] width,
    input  logic [COORD_BITS-1:0] height,
    input  logic [PIXEL_BITS-1:0] color,
    output logic                  write_burst_req,
    output logic [BURST_BITS-1:0] write_burst_len,
    output logic [ADDR_BITS-1:0]  addr,
    output logic [PIXEL_BITS-1:0] rgb,
    input  logic                  write_burst_data_req,
    input  logic                  write_burst_data_finish,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = COORD_BITS + 1;
    localparam logic [CW-1:0] SW = CW'(SCREEN_WIDTH);
    localparam logic [CW-1:0] SH = CW'(SCREEN_HEIGHT);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [COORD_BITS-1:0] W_ONE = COORD_BITS'(1);
    localparam logic [ADDR_BITS-1:0] PITCH = ADDR_BITS'(SCREEN_WIDTH);
    localparam logic [ADDR_BITS-1:0] BASE = ADDR_BITS'(FB_BASE);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_REQ, S_DATA, S_NEXT, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_FULL, PH_LEFT, PH_RIGHT
    } phase_t;

    state_t st, st_n;
    phase_t phase, t_phase, n_phase;

    logic                  mode_q;
    logic [COORD_BITS-1:0] x_q, y_q, w_q, h_q;
    logic [PIXEL_BITS-1:0] color_q;
    logic [CW-1:0]         x_end_q, y_end_q;
    logic [CW-1:0]         row, col, seg_end;
    logic [ADDR_BITS-1:0]  addr_q, t_addr;
    logic [BURST_BITS-1:0] len_q, t_len;

    logic [CW-1:0] x_w, y_h, x_end_c, y_end_c;
    logic [CW-1:0] x_right, y_bot;
    logic [CW-1:0] nxt_col, nr;
    logic [CW-1:0] n_row, n_col, n_end;
    logic [CW-1:0] t_row, t_col, t_end, rem;
    logic          empty, right_ok, n_last, load;

    // Clip extents are computed one bit wider than the inputs so they never wrap
    always_comb begin
        x_w     = CW'(x_q) + CW'(w_q);
        y_h     = CW'(y_q) + CW'(h_q);
        x_end_c = (x_w > SW) ? SW : x_w;
        y_end_c = (y_h > SH) ? SH : y_h;
        x_right = x_w - ONE;
        y_bot   = y_h - ONE;
        empty   = (w_q == '0) || (h_q == '0) ||
                  (CW'(x_q) >= SW) || (CW'(y_q) >= SH);
    end

    // Where the engine goes after the burst that just finished
    always_comb begin
        nxt_col  = col + CW'(len_q);
        nr       = row + ONE;
        right_ok = mode_q && (phase == PH_LEFT) &&
                   (w_q > W_ONE) && (x_right < SW);
        n_row    = row;
        n_col    = nxt_col;
        n_end    = seg_end;
        n_phase  = phase;
        n_last   = 1'b0;
        if (nxt_col < seg_end) begin
            n_col = nxt_col;
        end else if (right_ok) begin
            n_col   = x_right;
            n_end   = x_right + ONE;
            n_phase = PH_RIGHT;
        end else if (nr >= y_end_q) begin
            n_last = 1'b1;
        end else begin
            n_row = nr;
            n_col = CW'(x_q);
            if (!mode_q || (nr == y_bot)) begin
                n_end   = x_end_q;
                n_phase = PH_FULL;
            end else begin
                n_end   = CW'(x_q) + ONE;
                n_phase = PH_LEFT;
            end
        end
    end

    // Burst target: first segment in SETUP, otherwise the advanced position
    always_comb begin
        if (st == S_SETUP) begin
            t_row   = CW'(y_q);
            t_col   = CW'(x_q);
            t_end   = x_end_c;
            t_phase = PH_FULL;
        end else begin
            t_row   = n_row;
            t_col   = n_col;
            t_end   = n_end;
            t_phase = n_phase;
        end
        rem = t_end - t_col;
        if (int'(rem) > MAX_BURST_LEN)
            t_len = BURST_BITS'(MAX_BURST_LEN);
        else
            t_len = BURST_BITS'(rem);
        t_addr = BASE + ADDR_BITS'(t_row) * PITCH + ADDR_BITS'(t_col);
        load   = ((st == S_SETUP) && !empty) ||
                 ((st == S_NEXT) && !n_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= S_IDLE;
        else
            st <= st_n;
    end

    always_comb begin
        st_n = st;
        unique case (st)
            S_IDLE:  if (start) st_n = S_SETUP;
            S_SETUP: st_n = empty ? S_DONE : S_REQ;
            S_REQ: begin
                if (write_burst_data_finish)
                    st_n = S_NEXT;
                else if (write_burst_data_req)
                    st_n = S_DATA;
            end
            S_DATA:  if (write_burst_data_finish) st_n = S_NEXT;
            S_NEXT:  st_n = n_last ? S_DONE : S_REQ;
            S_DONE:  st_n = S_IDLE;
            default: st_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            row     <= '0;
            col     <= '0;
            seg_end <= '0;
            phase   <= PH_FULL;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            if ((st == S_IDLE) && start) begin
                mode_q  <= mode;
                x_q     <= x_pixel;
                y_q     <= y_pixel;
                w_q     <= width;
                h_q     <= height;
                color_q <= color;
            end
            if (st == S_SETUP) begin
                x_end_q <= x_end_c;
                y_end_q <= y_end_c;
            end
            if (load) begin
                row     <= t_row;
                col     <= t_col;
                seg_end <= t_end;
                phase   <= t_phase;
                addr_q  <= t_addr;
                len_q   <= t_len;
            end
        end
    end

    assign write_burst_req = (st == S_REQ);
    assign write_burst_len = len_q;
    assign addr            = addr_q;
    assign rgb             = color_q;
    assign busy            = (st == S_SETUP) || (st == S_REQ) ||
                             (st == S_DATA) || (st == S_NEXT);
    assign done            = (st == S_DONE);

endmodule

// File: tb/tb_rect_draw_engine.sv
// Bench for rect_draw_engine: command table, burst scoreboard and
// hand-written reset / mid-command sequences.
module tb_rect_draw_engine;

    localparam int AB = 22;
    localparam int BB = 10;
    localparam int CB = 10;
    localparam int PB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [CB-1:0] x_pixel, y_pixel, width, height;
    logic [PB-1:0] color;
    logic          write_burst_req;
    logic [BB-1:0] write_burst_len;
    logic [AB-1:0] addr;
    logic [PB-1:0] rgb;
    logic          write_burst_data_req;
    logic          write_burst_data_finish;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    rect_draw_engine dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .x_pixel(x_pixel),
        .y_pixel(y_pixel),
        .width(width),
        .height(height),
        .color(color),
        .write_burst_req(write_burst_req),
        .write_burst_len(write_burst_len),
        .addr(addr),
        .rgb(rgb),
        .write_burst_data_req(write_burst_data_req),
        .write_burst_data_finish(write_burst_data_finish),
        .busy(busy),
        .done(done)
    );

    typedef struct packed {
        logic [AB-1:0] a;
        logic [BB-1:0] l;
    } burst_t;

    typedef struct packed {
        logic              m;
        logic [CB-1:0]     x;
        logic [CB-1:0]     y;
        logic [CB-1:0]     w;
        logic [CB-1:0]     h;
        logic [PB-1:0]     c;
        logic              fir;
        logic              ms;
        logic [2:0]        nb;
        logic [3:0][AB-1:0] ea;
        logic [3:0][BB-1:0] el;
    } vec_t;

    vec_t   vecs[11];
    burst_t sbq[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit m, input int x, input int y,
                                input int w, input int h, input int c,
                                input bit fir, input bit ms, input int nb,
                                input int a0, input int l0,
                                input int a1, input int l1,
                                input int a2, input int l2,
                                input int a3, input int l3);
        vec_t v;
        v.m = m;
        v.x = CB'(x);
        v.y = CB'(y);
        v.w = CB'(w);
        v.h = CB'(h);
        v.c = PB'(c);
        v.fir = fir;
        v.ms = ms;
        v.nb = 3'(nb);
        v.ea[0] = AB'(a0); v.el[0] = BB'(l0);
        v.ea[1] = AB'(a1); v.el[1] = BB'(l1);
        v.ea[2] = AB'(a2); v.el[2] = BB'(l2);
        v.ea[3] = AB'(a3); v.el[3] = BB'(l3);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int     cyc;
        int     words;
        int     nreq;
        bit     got_done;
        bit     in_data;
        burst_t e;
        for (int i = 0; i < int'(v.nb); i++) begin
            e.a = v.ea[i];
            e.l = v.el[i];
            sbq.push_back(e);
        end
        @(negedge clk);
        mode = v.m;
        x_pixel = v.x;
        y_pixel = v.y;
        width = v.w;
        height = v.h;
        color = v.c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~v.m;
        x_pixel = CB'(3);
        y_pixel = CB'(3);
        width = CB'(7);
        height = CB'(7);
        color = '1;
        chk($sformatf("busy_after_start v%0d", id), 32'(busy), 32'd1);
        cyc = 1;
        got_done = 1'b0;
        in_data = 1'b0;
        words = 0;
        nreq = 0;
        while (!got_done && cyc < 3000) begin
            write_burst_data_req = 1'b0;
            write_burst_data_finish = 1'b0;
            start = 1'b0;
            if (done) begin
                got_done = 1'b1;
                chk($sformatf("busy_at_done v%0d", id), 32'(busy), 32'd0);
                if (v.nb == 3'd0)
                    chk($sformatf("empty_latency v%0d", id), 32'(cyc), 32'd2);
                if (v.ms)
                    start = 1'b1;
            end else begin
                if (v.ms && cyc == 3)
                    start = 1'b1;
                if (write_burst_req) begin
                    nreq++;
                    chk($sformatf("req_in_data v%0d", id), 32'(in_data), 32'd0);
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_burst v%0d addr %0d expected none",
                                 id, addr);
                        words = int'(write_burst_len) - 1;
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("addr v%0d", id), 32'(addr), 32'(e.a));
                        chk($sformatf("len v%0d", id), 32'(write_burst_len),
                            32'(e.l));
                        chk($sformatf("rgb v%0d", id), 32'(rgb), 32'(v.c));
                        words = int'(e.l) - 1;
                    end
                    if (v.fir) begin
                        write_burst_data_finish = 1'b1;
                    end else begin
                        write_burst_data_req = 1'b1;
                        in_data = 1'b1;
                    end
                end else if (in_data) begin
                    if (words > 0) begin
                        write_burst_data_req = 1'b1;
                        words--;
                    end else begin
                        chk($sformatf("rgb_data v%0d", id), 32'(rgb), 32'(v.c));
                        write_burst_data_finish = 1'b1;
                        in_data = 1'b0;
                    end
                end
            end
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL timeout v%0d got no done expected done", id);
        end
        chk($sformatf("bursts_missing v%0d", id), 32'(sbq.size()), 32'd0);
        chk($sformatf("req_cycles v%0d", id), 32'(nreq), 32'(v.nb));
        sbq.delete();
        @(negedge clk);
        start = 1'b0;
        write_burst_data_req = 1'b0;
        write_burst_data_finish = 1'b0;
        chk($sformatf("done_pulse v%0d", id), 32'(done), 32'd0);
        chk($sformatf("idle_busy v%0d", id), 32'(busy), 32'd0);
        @(negedge clk);
        chk($sformatf("idle_req v%0d", id), 32'(write_burst_req), 32'd0);
    endtask

    initial begin
        int k;
        bit saw_done;
        vecs[0]  = mk(0, 10, 20, 4, 2, 16'hA5A5, 0, 0, 2,
                      12810, 4, 13450, 4, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 300, 1, 16'h1111, 0, 0, 3,
                      0, 128, 128, 128, 256, 44, 0, 0);
        vecs[2]  = mk(0, 630, 478, 20, 5, 16'h2222, 0, 0, 2,
                      306550, 10, 307190, 10, 0, 0, 0, 0);
        vecs[3]  = mk(1, 5, 5, 3, 3, 16'h3333, 0, 0, 4,
                      3205, 3, 3845, 1, 3847, 1, 4485, 3);
        vecs[4]  = mk(0, 1, 1, 0, 3, 16'h4444, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 700, 1, 5, 5, 16'h5555, 0, 1, 0,
                      0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 2, 3, 6, 2, 16'h6666, 1, 1, 2,
                      1922, 6, 2562, 6, 0, 0, 0, 0);
        vecs[7]  = mk(1, 100, 0, 1, 3, 16'h7777, 0, 0, 3,
                      100, 1, 740, 1, 1380, 1, 0, 0);
        vecs[8]  = mk(1, 636, 478, 10, 5, 16'h8888, 0, 0, 2,
                      306556, 4, 307196, 1, 0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 10, 3, 1, 16'h9999, 0, 0, 1,
                      6400, 3, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 1, 1, 2, 2, 16'hAAAA, 0, 0, 2,
                      641, 2, 1281, 2, 0, 0, 0, 0);

        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        x_pixel = '0;
        y_pixel = '0;
        width = '0;
        height = '0;
        color = '0;
        write_burst_data_req = 1'b0;
        write_burst_data_finish = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_req", 32'(write_burst_req), 32'd0);
        chk("reset_len", 32'(write_burst_len), 32'd0);
        chk("reset_addr", 32'(addr), 32'd0);
        chk("reset_rgb", 32'(rgb), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], i);

        // Reset while a burst is in its data phase
        @(negedge clk);
        mode = 1'b0;
        x_pixel = CB'(0);
        y_pixel = CB'(0);
        width = CB'(20);
        height = CB'(1);
        color = PB'(16'h1234);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!write_burst_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_seq_req_seen", 32'(write_burst_req), 32'd1);
        write_burst_data_req = 1'b1;
        @(negedge clk);
        write_burst_data_req = 1'b0;
        chk("rst_seq_rgb_before", 32'(rgb), 32'h1234);
        chk("rst_seq_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", 32'(write_burst_req), 32'd0);
        chk("rst_mid_len", 32'(write_burst_len), 32'd0);
        chk("rst_mid_addr", 32'(addr), 32'd0);
        chk("rst_mid_rgb", 32'(rgb), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || write_burst_req)
                saw_done = 1'b1;
        end
        chk("rst_no_done", 32'(saw_done), 32'd0);

        run_vec(vecs[0], 100);
        run_vec(vecs[3], 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
